// File: rtl/mac_unit_pkg.sv
// Shared width defaults and saturation-limit helpers for the multiply-accumulate slice.
// Limits are returned 64 bits wide; callers keep the low ACC_W bits.
package mac_unit_pkg;

  localparam int DEF_X_W   = 4;
  localparam int DEF_W_W   = 4;
  localparam int DEF_ACC_W = 8;
  localparam int LIM_W     = 64;

  // Largest representable accumulator value: 2^(acc_w-1)-1 signed, 2^acc_w-1 unsigned.
  function automatic logic [LIM_W-1:0] sat_max(input int acc_w, input logic is_signed);
    logic [LIM_W-1:0] one;
    one = 1;
    if (is_signed) sat_max = (one << (acc_w - 1)) - one;
    else           sat_max = (one << acc_w) - one;
  endfunction

  // Smallest representable value as a raw bit pattern: 100..0 signed, zero unsigned.
  function automatic logic [LIM_W-1:0] sat_min(input int acc_w, input logic is_signed);
    logic [LIM_W-1:0] one;
    one = 1;
    if (is_signed) sat_min = one << (acc_w - 1);
    else           sat_min = '0;
  endfunction

endpackage

// File: rtl/mac_unit_mult.sv
// Purely combinational X_W x W_W multiplier; signed_mode selects two's-complement
// or unsigned interpretation of both operands.
module mac_mult #(
  parameter int X_W = 4,
  parameter int W_W = 4
) (
  input  logic               signed_mode,
  input  logic [X_W-1:0]     x,
  input  logic [W_W-1:0]     w,
  output logic [X_W+W_W-1:0] prod
);

  localparam int P_W = X_W + W_W;

  logic [P_W-1:0] x_ext;
  logic [P_W-1:0] w_ext;

  // Extending both operands to the full product width and keeping the low P_W
  // bits gives the exact result for either signedness with one multiplier.
  always_comb begin
    x_ext = {{W_W{signed_mode & x[X_W-1]}}, x};
    w_ext = {{X_W{signed_mode & w[W_W-1]}}, w};
    prod  = x_ext * w_ext;
  end

endmodule

// File: rtl/mac_unit.sv
// Single-stage saturating multiply-accumulate: out <= sat(previous_out + x*w).
// previous_out reaches out only through the output register, so instances chain as a pipeline.
module mac_unit
  import mac_unit_pkg::*;
#(
  parameter int X_W   = DEF_X_W,
  parameter int W_W   = DEF_W_W,
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             signed_mode,
  input  logic [X_W-1:0]   x,
  input  logic [W_W-1:0]   w,
  input  logic [ACC_W-1:0] previous_out,
  output logic [ACC_W-1:0] out,
  output logic             out_valid,
  output logic             ovf
);

  localparam int P_W = X_W + W_W;

  localparam logic [ACC_W-1:0] S_MAX = ACC_W'(sat_max(ACC_W, 1'b1));
  localparam logic [ACC_W-1:0] S_MIN = ACC_W'(sat_min(ACC_W, 1'b1));
  localparam logic [ACC_W-1:0] U_MAX = ACC_W'(sat_max(ACC_W, 1'b0));

  logic [P_W-1:0]   prod;
  logic [ACC_W:0]   prod_ext;
  logic [ACC_W:0]   prev_ext;
  logic [ACC_W:0]   sum;
  logic [ACC_W-1:0] out_next;
  logic             ovf_next;

  mac_mult #(
    .X_W (X_W),
    .W_W (W_W)
  ) u_mult (
    .signed_mode (signed_mode),
    .x           (x),
    .w           (w),
    .prod        (prod)
  );

  // One extra bit of headroom holds any sum exactly, so overflow is read from the top two bits.
  always_comb begin
    prod_ext = {{(ACC_W + 1 - P_W){signed_mode & prod[P_W-1]}}, prod};
    prev_ext = {signed_mode & previous_out[ACC_W-1], previous_out};
    sum      = prod_ext + prev_ext;
    out_next = sum[ACC_W-1:0];
    ovf_next = 1'b0;
    if (signed_mode) begin
      if (sum[ACC_W] != sum[ACC_W-1]) begin
        ovf_next = 1'b1;
        out_next = sum[ACC_W] ? S_MIN : S_MAX;
      end
    end else if (sum[ACC_W]) begin
      ovf_next = 1'b1;
      out_next = U_MAX;
    end
  end

  // rst_n is active-high despite its name.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      out       <= '0;
      out_valid <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out <= out_next;
        ovf <= ovf_next;
      end
    end
  end

endmodule

// File: tb/tb_mac_unit.sv
// Directed-vector bench for mac_unit at default widths (4x4 -> 8-bit accumulator).
module tb_mac_unit;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       signed_mode;
  logic [3:0] x;
  logic [3:0] w;
  logic [7:0] previous_out;
  logic [7:0] out;
  logic       out_valid;
  logic       ovf;

  int n_checks = 0;
  int n_fail   = 0;

  mac_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .signed_mode  (signed_mode),
    .x            (x),
    .w            (w),
    .previous_out (previous_out),
    .out          (out),
    .out_valid    (out_valid),
    .ovf          (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_fail++;
      $display("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Drive one accepted operand set and check the registered result one edge later.
  task automatic apply(input string tag, input logic sm, input logic [3:0] xv, input logic [3:0] wv,
                       input logic [7:0] pv, input logic [7:0] exp_out, input logic exp_ovf);
    @(negedge clk);
    in_valid     = 1'b1;
    signed_mode  = sm;
    x            = xv;
    w            = wv;
    previous_out = pv;
    @(posedge clk);
    #1;
    check({tag, ".out"}, {8'h0, out}, {8'h0, exp_out});
    check({tag, ".valid"}, {15'h0, out_valid}, 16'h1);
    check({tag, ".ovf"}, {15'h0, ovf}, {15'h0, exp_ovf});
  endtask

  // Idle cycle with junk operands: result must hold and out_valid must drop.
  task automatic idle(input string tag, input logic [7:0] exp_out, input logic exp_ovf);
    @(negedge clk);
    in_valid     = 1'b0;
    signed_mode  = ~signed_mode;
    x            = 4'hf;
    w            = 4'hf;
    previous_out = 8'h7f;
    @(posedge clk);
    #1;
    check({tag, ".out"}, {8'h0, out}, {8'h0, exp_out});
    check({tag, ".valid"}, {15'h0, out_valid}, 16'h0);
    check({tag, ".ovf"}, {15'h0, ovf}, {15'h0, exp_ovf});
  endtask

  initial begin
    rst_n        = 1'b1;
    in_valid     = 1'b0;
    signed_mode  = 1'b0;
    x            = '0;
    w            = '0;
    previous_out = '0;
    #1;
    check("rst.out", {8'h0, out}, 16'h0);
    check("rst.valid", {15'h0, out_valid}, 16'h0);
    check("rst.ovf", {15'h0, ovf}, 16'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;

    // Unsigned basics and hold behaviour
    apply("u_2x4", 1'b0, 4'd2, 4'd4, 8'd0, 8'd8, 1'b0);
    apply("u_3x9p8", 1'b0, 4'd3, 4'd9, 8'd8, 8'd35, 1'b0);
    for (int i = 0; i < 3; i++) idle("hold35", 8'd35, 1'b0);
    apply("u_sat", 1'b0, 4'd15, 4'd15, 8'd100, 8'd255, 1'b1);
    idle("hold_ovf", 8'd255, 1'b1);
    apply("u_225", 1'b0, 4'd15, 4'd15, 8'd0, 8'd225, 1'b0);
    apply("u_edge255", 1'b0, 4'd0, 4'd9, 8'd255, 8'd255, 1'b0);
    apply("u_edge256", 1'b0, 4'd1, 4'd1, 8'd255, 8'd255, 1'b1);

    // Signed, back-to-back with mode switching
    apply("s_neg_sat", 1'b1, 4'b1000, 4'd7, 8'h9c, 8'h80, 1'b1);
    apply("s_m3x5p20", 1'b1, 4'hd, 4'd5, 8'd20, 8'd5, 1'b0);
    apply("s_pos_sat", 1'b1, 4'd7, 4'd7, 8'd100, 8'd127, 1'b1);
    apply("s_m8xm8", 1'b1, 4'h8, 4'h8, 8'd0, 8'd64, 1'b0);
    apply("s_m1xm1", 1'b1, 4'hf, 4'hf, 8'd0, 8'd1, 1'b0);
    apply("u_15x15", 1'b0, 4'hf, 4'hf, 8'd0, 8'd225, 1'b0);
    apply("s_edge127", 1'b1, 4'd1, 4'd0, 8'd127, 8'd127, 1'b0);
    apply("s_edge128", 1'b1, 4'd1, 4'd1, 8'd127, 8'd127, 1'b1);
    apply("s_edgem128", 1'b1, 4'hf, 4'd0, 8'h80, 8'h80, 1'b0);
    apply("s_edgem129", 1'b1, 4'hf, 4'd1, 8'h80, 8'h80, 1'b1);

    // Mid-cycle reset with an operation in flight
    apply("pre_rst", 1'b0, 4'd5, 4'd5, 8'd1, 8'd26, 1'b0);
    @(negedge clk);
    in_valid     = 1'b1;
    signed_mode  = 1'b0;
    x            = 4'd7;
    w            = 4'd3;
    previous_out = 8'd250;
    #2;
    rst_n = 1'b1;
    #1;
    check("midrst.out", {8'h0, out}, 16'h0);
    check("midrst.valid", {15'h0, out_valid}, 16'h0);
    check("midrst.ovf", {15'h0, ovf}, 16'h0);
    @(posedge clk);
    #1;
    check("inrst.out", {8'h0, out}, 16'h0);
    check("inrst.valid", {15'h0, out_valid}, 16'h0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    @(posedge clk);
    #1;
    check("post_rel.valid", {15'h0, out_valid}, 16'h0);
    check("post_rel.out", {8'h0, out}, 16'h0);
    apply("post_rst", 1'b0, 4'd1, 4'd1, 8'd0, 8'd1, 1'b0);
    idle("final_hold", 8'd1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
